// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: forward key expansion, round-key store, one round per clock.
// Optional key-schedule cache selected by defining AES_DEC_KEYCACHE_EN.
module aes_decrypt_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_text,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         done,
  output logic [9:0]   completed_round,
  output logic [127:0] plain_text
);
  typedef enum logic [2:0] {IDLE, KEYEXP, INIT, ROUND, FIN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // x^254 is the multiplicative inverse and conveniently maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, t;
    x2  = gf_mul(x, x);
    x3  = gf_mul(x2, x);
    t   = gf_mul(x3, x3);
    x12 = gf_mul(t, t);
    t   = gf_mul(x12, x3);
    t   = gf_mul(t, t);
    t   = gf_mul(t, t);
    t   = gf_mul(t, t);
    t   = gf_mul(t, t);
    t   = gf_mul(t, x12);
    return gf_mul(t, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // InvShiftRows + InvSubBytes + AddRoundKey, then InvMixColumns except in the last round
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic mix);
    logic [127:0] v;
    v = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        v[127 - 8*(4*c + r) -: 8] = inv_sbox(s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
    v = v ^ k;
    if (mix)
      for (int unsigned c = 0; c < 4; c++)
        v[127 - 32*c -: 32] = inv_mix_col(v[127 - 32*c -: 32]);
    return v;
  endfunction

  state_t       st;
  logic [3:0]   cnt;
  logic [7:0]   rcon;
  logic [127:0] ct_q, wk, blk;
  logic [127:0] rk [0:10];
  logic [127:0] next_key, next_blk;
`ifdef AES_DEC_KEYCACHE_EN
  logic         key_valid;
`endif

  always_comb begin
    next_key = expand(wk, rcon);
    next_blk = inv_round(blk, rk[cnt], cnt != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st              <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      completed_round <= '0;
      plain_text      <= '0;
      cnt             <= '0;
      rcon            <= 8'h01;
      ct_q            <= '0;
      wk              <= '0;
      blk             <= '0;
`ifdef AES_DEC_KEYCACHE_EN
      key_valid       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: if (start) begin
          ct_q            <= cipher_text;
          completed_round <= '0;
          busy            <= 1'b1;
          rk[0]           <= cipher_key;
          wk              <= cipher_key;
          cnt             <= 4'd1;
          rcon            <= 8'h01;
          st              <= KEYEXP;
`ifdef AES_DEC_KEYCACHE_EN
          // rk[0] doubles as the cached key; rewriting it on a hit is harmless
          if (key_valid && cipher_key == rk[0]) st <= INIT;
          else key_valid <= 1'b0;
`endif
        end
        KEYEXP: begin
          rk[cnt] <= next_key;
          wk      <= next_key;
          rcon    <= xtime(rcon);
          if (cnt == 4'd10) begin
            st <= INIT;
`ifdef AES_DEC_KEYCACHE_EN
            key_valid <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        INIT: begin
          blk <= ct_q ^ rk[10];
          cnt <= 4'd9;
          st  <= ROUND;
        end
        ROUND: begin
          blk             <= next_blk;
          completed_round <= {completed_round[8:0], 1'b1};
          if (cnt == 4'd0) st <= FIN;
          else cnt <= cnt - 4'd1;
        end
        FIN: begin
          plain_text <= blk;
          done       <= 1'b1;
          busy       <= 1'b0;
          st         <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule
